uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters. A grant is held for a whole message, which ends on the requester's `last` flag or on a byte cap. While holding a grant, the arbiter hands bytes to `uart_tx` one at a time using the `uart_tx_start` / `uart_tx_done` handshake. It sits in front of `uart_tx`, alongside `uart_tx_control`-style message sources.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `MAX_BYTES`, 16: maximum bytes per grant; legal range 1..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: bit i means requester i presents a byte.
- `req_data` input `8*NUM_REQ`: byte of requester i is `req_data[8*i+7:8*i]`.
- `req_last` input `NUM_REQ`: the presented byte is the final byte of its message.
- `req_ready` output `NUM_REQ`: a byte transfers on an edge where `req_valid[i]` and `req_ready[i]` are both high.
- `grant_id` output `$clog2(NUM_REQ)`: index of the current or most recent grantee.
- `busy` output 1: high whenever state is not IDLE.
- `uart_tx_start` output 1: single-cycle pulse telling `uart_tx` to send `uart_tx_data`.
- `uart_tx_data` output 8: byte for `uart_tx`; held stable from the start pulse until the next load.
- `uart_tx_done` input 1: single-cycle pulse from `uart_tx` when a byte has finished.
- `msg_done` output 1: single-cycle pulse when a grant ends on `req_last`.
- `msg_truncated` output 1: single-cycle pulse when a grant ends on the `MAX_BYTES` cap without `last`.

## Operation
- **States:** IDLE, LOAD, WAIT. 3-bit encoding; any illegal state goes to IDLE.
- **Reset values:**
  - `uart_tx_start`, `uart_tx_data`, `grant_id`, `msg_done`, `msg_truncated`, `byte_cnt` are all 0.
  - `busy` and `req_ready` are 0.
  - Round-robin pointer `rr_ptr` is `NUM_REQ-1`, so requester 0 has first priority.
- **IDLE:**
  - If any `req_valid` bit is high, search indices `rr_ptr+1`, `rr_ptr+2`, … modulo `NUM_REQ`.
  - The first valid index is registered into `grant_id`, `byte_cnt` is cleared, and state goes to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:**
  - `req_ready[i] = (state==LOAD) && (grant_id==i)`. It is decoded from registers only and does not depend on `req_valid`.
  - On a transfer edge: `uart_tx_data <= byte`, `uart_tx_start <= 1`, `byte_cnt <= byte_cnt+1`, latch `req_last` into `last_q`, then go to WAIT.
  - If the grantee's valid is low, stay in LOAD holding the grant. Other requesters are not considered.
- **WAIT:**
  - `uart_tx_start <= 0` on the first edge in WAIT.
  - On `uart_tx_done`:
    - If `last_q` is set: pulse `msg_done`, set `rr_ptr <= grant_id`, go to IDLE.
    - Else if `byte_cnt == MAX_BYTES`: pulse `msg_truncated`, set `rr_ptr <= grant_id`, go to IDLE.
    - Otherwise go to LOAD.
  - If `last_q` and the cap coincide, only `msg_done` pulses.
- **`uart_tx_done` outside WAIT** is ignored.
- **Byte counter:** `byte_cnt` is `$clog2(MAX_BYTES+1)` bits wide and never wraps, because the grant is released at `MAX_BYTES`.
- **After truncation,** the requester's remaining bytes form a new message that is arbitrated normally.
- **Reset mid-operation:** all outputs and state return to their reset values immediately. Any byte already started in `uart_tx` is not tracked further.

## Timing
- **Grant latency:**
  - `req_valid` sampled in IDLE at edge k gives LOAD, `grant_id`, `busy=1`, and `req_ready` visible after edge k.
  - The byte transfers at edge k+1.
  - `uart_tx_start` is high for exactly one cycle, from edge k+1 to edge k+2.
- **Data stability:** `uart_tx_data` is valid in the same cycle as `uart_tx_start` and unchanged until the next transfer.
- **`uart_tx_done`** is sampled from edge k+2 onward.
- **End-of-grant pulses:** `msg_done` / `msg_truncated` go high for one cycle, registered on the same edge as the WAIT→IDLE transition.
- **Back-to-back bytes in one grant:**
  - `uart_tx_done` at edge d gives LOAD after d, transfer at edge d+1, and a start pulse after d+1.
  - Minimum 2 cycles from done to the next start.
- **Back-to-back grants:**
  - IDLE is visited for exactly one cycle between grants; the next `grant_id` registers at the edge leaving IDLE.
  - Minimum 3 cycles from the final `uart_tx_done` to the next start.

## Test plan
- **Single message:** requester 0 sends 0xA1, 0xA2, 0xA3 (last on 0xA3), with a `uart_tx` model giving done 10 cycles after start. Required: three start pulses with data 0xA1/0xA2/0xA3, `grant_id=0`, one `msg_done` pulse after the third done, then `busy=0`.
- **Rotation:** requesters 0, 1, 2 continuously valid with one-byte messages (last=1) of 0x10+i. Required grant order 0,1,2,0,1,2 and data 0x10,0x11,0x12,0x10,0x11,0x12.
- **Cap:** `MAX_BYTES=4`; requester 1 sends 6 bytes 0x01..0x06 with last only on 0x06. Required: `msg_truncated` after 0x04's done; requester 3 (valid, waiting) is served next; requester 1 then sends 0x05, 0x06 followed by `msg_done`.
- **Grantee stall:** requester 2 holds valid low for 5 cycles between bytes while requester 0 is valid. Required: no start pulse, `grant_id` stays 2, `req_ready[0]=0`; the next byte transfers on the edge valid returns.
- **Spurious done and reset:** a `uart_tx_done` pulse in IDLE produces no output change. `rst` asserted mid-WAIT clears every output asynchronously; after release, with requesters 0 and 3 valid, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte-stream bus and uart_tx start/done handshake shared by the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_start;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_done;

  modport master (
    output req_valid, req_data, req_last, uart_tx_done,
    input  req_ready, uart_tx_start, uart_tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_done,
    output req_ready, uart_tx_start, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte streams; a grant
// lasts a whole message, ending on last or after MAX_BYTES bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BYTES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       msg_done,
  output logic                       msg_truncated
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  next_id;
  logic             any_valid;
  logic [CNT_W-1:0] byte_cnt;
  logic             last_q;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [NUM_REQ-1:0] ready;
  logic [7:0]       sel_byte;
  logic             sel_valid;
  logic             sel_last;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from farthest to nearest offset so the nearest valid index after rr_ptr wins.
  always_comb begin
    next_id   = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[wrap_idx(rr_ptr, k)]) begin
        next_id   = wrap_idx(rr_ptr, k);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = (state == LOAD) && (grant_id == ID_W'(i));
    end
  end

  assign sel_byte  = bus.req_data[{grant_id, 3'b000} +: 8];
  assign sel_valid = bus.req_valid[grant_id];
  assign sel_last  = bus.req_last[grant_id];

  assign bus.req_ready     = ready;
  assign bus.uart_tx_start = tx_start;
  assign bus.uart_tx_data  = tx_data;
  assign busy              = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      grant_id      <= '0;
      byte_cnt      <= '0;
      last_q        <= 1'b0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      msg_done      <= 1'b0;
      msg_truncated <= 1'b0;
    end else begin
      msg_done      <= 1'b0;
      msg_truncated <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= next_id;
            byte_cnt <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (sel_valid) begin
            tx_data  <= sel_byte;
            tx_start <= 1'b1;
            byte_cnt <= byte_cnt + CNT_W'(1);
            last_q   <= sel_last;
            state    <= WAIT;
          end
        end
        WAIT: begin
          tx_start <= 1'b0;
          if (bus.uart_tx_done) begin
            // last takes precedence when it coincides with the byte cap.
            if (last_q) begin
              msg_done <= 1'b1;
              rr_ptr   <= grant_id;
              state    <= IDLE;
            end else if (byte_cnt == CNT_W'(MAX_BYTES)) begin
              msg_truncated <= 1'b1;
              rr_ptr        <= grant_id;
              state         <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters, a uart_tx latency model,
// and expected byte/end-of-message queues compared as the DUT produces them.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BYTES = 4;
  localparam int DONE_LAT  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  logic [1:0] grant_id;
  logic       busy;
  logic       msg_done;
  logic       msg_truncated;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant_id(grant_id),
    .busy(busy),
    .msg_done(msg_done),
    .msg_truncated(msg_truncated)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]         rq[NUM_REQ][$];   // {last, data} per requester
  logic [NUM_REQ-1:0] stall = '0;
  logic [NUM_REQ-1:0] fire  = '0;
  logic [9:0]         exp_q[$];         // {grant_id, data}
  logic [3:0]         end_q[$];         // {truncated, done, grant_id}
  logic               model_done = 1'b0;
  logic               spur_done  = 1'b0;
  int                 lat_cnt    = 0;

  assign bus.uart_tx_done = model_done | spur_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic last);
    rq[i].push_back({last, d});
  endtask

  task automatic exp_byte(input int g, input logic [7:0] d);
    exp_q.push_back({2'(g), d});
  endtask

  task automatic exp_end(input logic trunc, input int g);
    end_q.push_back({trunc, ~trunc, 2'(g)});
  endtask

  function automatic logic pending();
    logic p;
    p = busy || (exp_q.size() != 0) || (end_q.size() != 0);
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pending() && n < budget);
    check("idle_timeout", {31'd0, pending()}, 0);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.uart_tx_start && n < budget);
    check("start_timeout", {31'd0, bus.uart_tx_start}, 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    end_q.delete();
    stall = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Requester models: present queue heads, pop after a transfer edge.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ-1:0]   l;
    logic [8*NUM_REQ-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0 && !stall[i]) begin
        v[i]        = 1'b1;
        l[i]        = rq[i][0][8];
        d[8*i +: 8] = rq[i][0][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    fire = v & bus.req_ready & {NUM_REQ{~rst}};
  end

  // uart_tx model and scoreboard comparisons.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [3:0] x;
    model_done = 1'b0;
    if (rst) begin
      lat_cnt = 0;
    end else begin
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) model_done = 1'b1;
      end
      if (bus.uart_tx_start) begin
        if (exp_q.size() == 0) begin
          check("start_unexpected", {24'd0, bus.uart_tx_data}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {24'd0, bus.uart_tx_data}, {24'd0, e[7:0]});
          check("tx_gid", {30'd0, grant_id}, {30'd0, e[9:8]});
        end
        lat_cnt = DONE_LAT;
      end
      if (msg_done || msg_truncated) begin
        if (end_q.size() == 0) begin
          check("end_unexpected", {30'd0, msg_truncated, msg_done}, 0);
        end else begin
          x = end_q.pop_front();
          check("end_evt", {28'd0, msg_truncated, msg_done, grant_id}, {28'd0, x});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {28'd0, bus.req_ready}, 0);
    check("rst_start", {31'd0, bus.uart_tx_start}, 0);
    check("rst_data", {24'd0, bus.uart_tx_data}, 0);
    check("rst_gid", {30'd0, grant_id}, 0);
    check("rst_done", {31'd0, msg_done}, 0);
    check("rst_trunc", {31'd0, msg_truncated}, 0);
    rst = 1'b0;

    // Single message from requester 0.
    send(0, 8'hA1, 0); send(0, 8'hA2, 0); send(0, 8'hA3, 1);
    exp_byte(0, 8'hA1); exp_byte(0, 8'hA2); exp_byte(0, 8'hA3);
    exp_end(0, 0);
    wait_idle(400);
    check("single_busy", {31'd0, busy}, 0);

    // Rotation among requesters 0..2.
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++) begin
        send(i, 8'(8'h10 + i), 1);
        exp_byte(i, 8'(8'h10 + i));
        exp_end(0, i);
      end
    wait_idle(600);

    // Byte cap truncation with requester 3 waiting.
    reset_dut();
    for (int b = 1; b <= 6; b++) send(1, 8'(b), (b == 6));
    send(3, 8'h30, 1);
    for (int b = 1; b <= 4; b++) exp_byte(1, 8'(b));
    exp_end(1, 1);
    exp_byte(3, 8'h30); exp_end(0, 3);
    exp_byte(1, 8'h05); exp_byte(1, 8'h06); exp_end(0, 1);
    wait_idle(800);

    // Grantee stall: requester 2 holds valid low while requester 0 waits.
    reset_dut();
    send(2, 8'h21, 0); send(2, 8'h22, 1);
    exp_byte(2, 8'h21); exp_byte(2, 8'h22); exp_end(0, 2);
    exp_byte(0, 8'h01); exp_end(0, 0);
    wait_start(20);
    send(0, 8'h01, 1);
    stall[2] = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!bus.req_ready[2] && n < 40);
      check("stall_load_timeout", {31'd0, bus.req_ready[2]}, 1);
    end
    for (int c = 0; c < 5; c++) begin
      check("stall_start", {31'd0, bus.uart_tx_start}, 0);
      check("stall_gid", {30'd0, grant_id}, 2);
      check("stall_ready0", {31'd0, bus.req_ready[0]}, 0);
      @(posedge clk); #1;
    end
    stall[2] = 1'b0;
    @(posedge clk); #1;
    check("stall_resume", {31'd0, bus.uart_tx_start}, 1);
    wait_idle(400);

    // Spurious done while idle.
    @(negedge clk) spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    @(posedge clk); #1;
    check("spur_busy", {31'd0, busy}, 0);
    check("spur_start", {31'd0, bus.uart_tx_start}, 0);
    check("spur_done", {30'd0, msg_truncated, msg_done}, 0);
    check("spur_gid", {30'd0, grant_id}, 0);
    check("spur_data", {24'd0, bus.uart_tx_data}, 32'h01);

    // Asynchronous reset in the middle of WAIT.
    send(1, 8'h55, 1);
    exp_byte(1, 8'h55);
    wait_start(20);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_data", {24'd0, bus.uart_tx_data}, 0);
    check("arst_gid", {30'd0, grant_id}, 0);
    check("arst_ready", {28'd0, bus.req_ready}, 0);
    check("arst_start", {31'd0, bus.uart_tx_start}, 0);
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    end_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0, 8'h0A, 1); send(3, 8'h3A, 1);
    exp_byte(0, 8'h0A); exp_end(0, 0);
    exp_byte(3, 8'h3A); exp_end(0, 3);
    wait_idle(400);

    check("exp_left", exp_q.size(), 0);
    check("end_left", end_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
